// File: rtl/fetch_sequencer.sv
// Fetch sequencer: IDLE/RUN/DONE control of the program counter and retire count.
// Ports: Clk, Reset(sync, low), Start, Instr, BranchEn, Offset, Hold -> ProgCtr, Running, Ack, InstCount.
module fetch_sequencer #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [8:0]       Instr,
  input  logic             BranchEn,
  input  logic [7:0]       Offset,
  input  logic             Hold,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Ack,
  output logic [CNT_W-1:0] InstCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic             is_ack;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  pc_br;
  logic [CNT_W-1:0] cnt_nxt;
  logic             unused_operands;

  assign is_ack = (Instr[8:5] == 4'b1111);

  // Offset is sign-extended to PC width; sums wrap modulo 2^PC_W.
  assign pc_inc = ProgCtr + PC_W'(1);
  assign pc_br  = pc_inc + PC_W'(signed'(Offset));

  // Retire counter sticks at all-ones.
  assign cnt_nxt = (&InstCount) ? InstCount
                                : InstCount + CNT_W'(1);

  assign unused_operands = ^Instr[4:0];

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      ProgCtr   <= '0;
      InstCount <= '0;
      Running   <= 1'b0;
      Ack       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            state   <= RUN;
            Running <= 1'b1;
          end
        end
        RUN: begin
          if (!Hold) begin
            InstCount <= cnt_nxt;
            if (is_ack) begin
              state   <= DONE;
              Running <= 1'b0;
              Ack     <= 1'b1;
            end else if (BranchEn) begin
              ProgCtr <= pc_br;
            end else begin
              ProgCtr <= pc_inc;
            end
          end
        end
        DONE: begin
          // Start must fall before another run can begin.
          if (!Start) begin
            state     <= IDLE;
            Ack       <= 1'b0;
            ProgCtr   <= '0;
            InstCount <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          ProgCtr   <= '0;
          InstCount <= '0;
          Running   <= 1'b0;
          Ack       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a queue of expected post-edge results.
// Each step drives inputs, pushes its expectation, clocks once, then checks.
module tb_fetch_sequencer;

  localparam int PC_W  = 10;
  localparam int CNT_W = 4;

  localparam logic [8:0] ADD = 9'h000;
  localparam logic [8:0] BNE = 9'h020;
  localparam logic [8:0] ACK = 9'h1E0;

  logic             Clk;
  logic             Reset;
  logic             Start;
  logic [8:0]       Instr;
  logic             BranchEn;
  logic [7:0]       Offset;
  logic             Hold;
  logic [PC_W-1:0]  ProgCtr;
  logic             Running;
  logic             Ack;
  logic [CNT_W-1:0] InstCount;

  typedef struct {
    string            tag;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] cnt;
    logic             run;
    logic             ack;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  fetch_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Instr    (Instr),
    .BranchEn (BranchEn),
    .Offset   (Offset),
    .Hold     (Hold),
    .ProgCtr  (ProgCtr),
    .Running  (Running),
    .Ack      (Ack),
    .InstCount(InstCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step(
    input string            tag,
    input logic             rs,
    input logic             st,
    input logic [8:0]       ins,
    input logic             br,
    input logic [7:0]       off,
    input logic             hd,
    input logic [PC_W-1:0]  pc,
    input logic [CNT_W-1:0] cnt,
    input logic             run,
    input logic             ack
  );
    exp_t e;
    Reset    = rs;
    Start    = st;
    Instr    = ins;
    BranchEn = br;
    Offset   = off;
    Hold     = hd;
    e.tag = tag;
    e.pc  = pc;
    e.cnt = cnt;
    e.run = run;
    e.ack = ack;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (ProgCtr === e.pc) else begin
      errors++;
      $error("FAIL %s pc got %h exp %h", e.tag, ProgCtr, e.pc);
    end
    checks++;
    assert (InstCount === e.cnt) else begin
      errors++;
      $error("FAIL %s cnt got %0d exp %0d", e.tag, InstCount, e.cnt);
    end
    checks++;
    assert (Running === e.run) else begin
      errors++;
      $error("FAIL %s run got %b exp %b", e.tag, Running, e.run);
    end
    checks++;
    assert (Ack === e.ack) else begin
      errors++;
      $error("FAIL %s ack got %b exp %b", e.tag, Ack, e.ack);
    end
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Instr = ADD;
    BranchEn = 1'b0; Offset = 8'h00; Hold = 1'b0;

    step("rst0", 0, 0, ADD, 0, 8'h00, 0, 10'h000, 4'd0, 0, 0);
    step("rst1", 0, 1, ADD, 1, 8'h05, 0, 10'h000, 4'd0, 0, 0);
    step("idle", 1, 0, ADD, 0, 8'h00, 0, 10'h000, 4'd0, 0, 0);

    step("go",   1, 1, ADD, 0, 8'h00, 0, 10'h000, 4'd0, 1, 0);
    step("add0", 1, 1, ADD, 0, 8'h00, 0, 10'h001, 4'd1, 1, 0);
    step("add1", 1, 1, ADD, 0, 8'h00, 0, 10'h002, 4'd2, 1, 0);
    step("add2", 1, 1, ADD, 0, 8'h00, 0, 10'h003, 4'd3, 1, 0);
    step("ack3", 1, 1, ACK, 1, 8'h10, 0, 10'h003, 4'd4, 0, 1);

    for (int i = 0; i < 10; i++)
      step("done", 1, 1, ADD, 1, 8'h01, 0, 10'h003, 4'd4, 0, 1);
    step("exit", 1, 0, ADD, 0, 8'h00, 0, 10'h000, 4'd0, 0, 0);
    step("idl2", 1, 0, ADD, 0, 8'h00, 0, 10'h000, 4'd0, 0, 0);
    step("rego", 1, 1, ADD, 0, 8'h00, 0, 10'h000, 4'd0, 1, 0);

    step("br+4", 1, 1, BNE, 1, 8'h04, 0, 10'h005, 4'd1, 1, 0);
    step("br-4", 1, 1, BNE, 1, 8'hFC, 0, 10'h002, 4'd2, 1, 0);
    step("br+2", 1, 1, BNE, 1, 8'h02, 0, 10'h005, 4'd3, 1, 0);
    step("br+3", 1, 1, BNE, 1, 8'h03, 0, 10'h009, 4'd4, 1, 0);
    step("bneg", 1, 1, BNE, 1, 8'hF5, 0, 10'h3FF, 4'd5, 1, 0);
    step("wrap", 1, 1, ADD, 0, 8'h00, 0, 10'h000, 4'd6, 1, 0);
    step("br-3", 1, 1, BNE, 1, 8'hFD, 0, 10'h3FE, 4'd7, 1, 0);
    step("bwrp", 1, 1, BNE, 1, 8'h05, 0, 10'h004, 4'd8, 1, 0);
    step("to7",  1, 1, BNE, 1, 8'h02, 0, 10'h007, 4'd9, 1, 0);

    for (int i = 0; i < 3; i++)
      step("hold", 1, 1, ACK, 1, 8'h10, 1, 10'h007, 4'd9, 1, 0);
    step("rel",  1, 1, ACK, 1, 8'h10, 0, 10'h007, 4'd10, 0, 1);

    step("exi2", 1, 0, ADD, 0, 8'h00, 0, 10'h000, 4'd0, 0, 0);
    step("go3",  1, 1, ADD, 0, 8'h00, 0, 10'h000, 4'd0, 1, 0);
    step("to12", 1, 1, BNE, 1, 8'h0B, 0, 10'h00C, 4'd1, 1, 0);
    step("mrst", 0, 1, ADD, 0, 8'h00, 0, 10'h000, 4'd0, 0, 0);
    step("mrs2", 0, 1, ADD, 1, 8'h03, 0, 10'h000, 4'd0, 0, 0);
    step("post", 1, 0, ADD, 0, 8'h00, 0, 10'h000, 4'd0, 0, 0);

    step("go4",  1, 1, ADD, 0, 8'h00, 0, 10'h000, 4'd0, 1, 0);
    for (int i = 0; i < 18; i++) begin
      logic [CNT_W-1:0] c;
      c = (i + 1 > 15) ? 4'd15 : CNT_W'(i + 1);
      step("sat", 1, 1, ADD, 0, 8'h00, 0, PC_W'(i + 1), c, 1, 0);
    end
    step("ack4", 1, 1, ACK, 0, 8'h00, 0, 10'h012, 4'd15, 0, 1);
    step("rst3", 0, 1, ADD, 0, 8'h00, 0, 10'h000, 4'd0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
